// File: rtl/channel_scheduler.sv
// Channel scheduler: turns decoded UART command frames into one-hot load/start/stop
// pulses for the serial-out channels and answers each accepted frame with a status byte.
module channel_scheduler #(
    parameter int         DATA_BIT = 32,
    parameter int         CH_NUM   = 16,
    parameter logic [7:0] CMD_FREQ = 8'h0A,
    parameter logic [7:0] CMD_DATA = 8'h0B,
    parameter logic [7:0] SLOW_DEF = 8'h14,
    parameter logic [7:0] FAST_DEF = 8'h05
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                done_tick_i,
    input  logic [7:0]          cmd_i,
    input  logic [DATA_BIT-1:0] output_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    input  logic [3:0]          sel_out_i,
    input  logic                mode_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [CH_NUM-1:0]   ch_busy_i,
    output logic [CH_NUM-1:0]   ch_load_o,
    output logic [CH_NUM-1:0]   ch_start_o,
    output logic [CH_NUM-1:0]   ch_stop_o,
    output logic [DATA_BIT-1:0] ch_pattern_o,
    output logic [DATA_BIT-1:0] ch_freq_o,
    output logic [7:0]          ch_slow_o,
    output logic [7:0]          ch_fast_o,
    output logic                ch_mode_o,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_tick_i,
    output logic                busy_o,
    output logic                overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_START,
        S_ACK,
        S_WAIT_TX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]          r_cmd;
    logic [DATA_BIT-1:0] r_pattern;
    logic [DATA_BIT-1:0] r_freqIn;
    logic [7:0]          r_slowIn;
    logic [7:0]          r_fastIn;
    logic [3:0]          r_sel;
    logic                r_mode;
    logic                r_startReq;
    logic                r_stopReq;
    logic [15:0]         r_busy;

    logic [DATA_BIT-1:0] r_freqReg;
    logic [7:0]          r_slowReg;
    logic [7:0]          r_fastReg;

    logic [CH_NUM-1:0]   r_load;
    logic [CH_NUM-1:0]   r_start;
    logic [CH_NUM-1:0]   r_stop;
    logic [DATA_BIT-1:0] r_chPattern;
    logic [DATA_BIT-1:0] r_chFreq;
    logic [7:0]          r_chSlow;
    logic [7:0]          r_chFast;
    logic                r_chMode;
    logic                r_txStart;
    logic [7:0]          r_txData;
    logic                r_overrun;

    logic [3:0]          w_status;
    logic [3:0]          w_ackStatus;
    logic [CH_NUM-1:0]   w_selOneHot;
    logic                w_doLoad;

    assign w_selOneHot = {{(CH_NUM-1){1'b0}}, 1'b1} << r_sel;
    // A pure stop request (stop=1, start=0) is the only case that does not reload.
    assign w_doLoad    = r_startReq | ~r_stopReq;
    assign w_ackStatus = (r_state == S_DECODE) ? w_status : 4'd0;

    always_comb begin
        w_status = 4'd0;
        if (r_cmd != CMD_FREQ && r_cmd != CMD_DATA) begin
            w_status = 4'd1;
        end else if (r_cmd == CMD_DATA) begin
            if (int'(r_sel) >= CH_NUM) begin
                w_status = 4'd2;
            end else if (r_busy[r_sel] && !r_stopReq) begin
                w_status = 4'd3;
            end
        end else if (r_fastIn == 8'd0 || r_slowIn <= r_fastIn) begin
            w_status = 4'd4;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (done_tick_i) w_next = S_DECODE;
            S_DECODE:  w_next = (w_status != 4'd0) ? S_ACK : S_EXEC;
            S_EXEC:    w_next = (r_cmd == CMD_DATA && r_startReq) ? S_START : S_ACK;
            S_START:   w_next = S_ACK;
            S_ACK:     w_next = S_WAIT_TX;
            S_WAIT_TX: if (tx_done_tick_i) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every pulse register is armed on the edge entering the state it belongs to,
    // so each pulse is high for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd       <= 8'd0;
            r_pattern   <= '0;
            r_freqIn    <= '0;
            r_slowIn    <= 8'd0;
            r_fastIn    <= 8'd0;
            r_sel       <= 4'd0;
            r_mode      <= 1'b0;
            r_startReq  <= 1'b0;
            r_stopReq   <= 1'b0;
            r_busy      <= 16'd0;
            r_freqReg   <= '0;
            r_slowReg   <= SLOW_DEF;
            r_fastReg   <= FAST_DEF;
            r_load      <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_chPattern <= '0;
            r_chFreq    <= '0;
            r_chSlow    <= 8'd0;
            r_chFast    <= 8'd0;
            r_chMode    <= 1'b0;
            r_txStart   <= 1'b0;
            r_txData    <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_load    <= '0;
            r_start   <= '0;
            r_stop    <= '0;
            r_txStart <= 1'b0;

            if (done_tick_i) begin
                if (r_state == S_IDLE) begin
                    r_cmd      <= cmd_i;
                    r_pattern  <= output_pattern_i;
                    r_freqIn   <= freq_pattern_i;
                    r_slowIn   <= slow_period_i;
                    r_fastIn   <= fast_period_i;
                    r_sel      <= sel_out_i;
                    r_mode     <= mode_i;
                    r_startReq <= start_i;
                    r_stopReq  <= stop_i;
                    r_busy     <= 16'(ch_busy_i);
                end else begin
                    r_overrun  <= 1'b1;
                end
            end

            if (r_state == S_DECODE && w_status == 4'd0) begin
                if (r_cmd == CMD_FREQ) begin
                    r_freqReg <= r_freqIn;
                    r_slowReg <= r_slowIn;
                    r_fastReg <= r_fastIn;
                end else begin
                    if (r_stopReq) begin
                        r_stop <= w_selOneHot;
                    end
                    if (w_doLoad) begin
                        r_load      <= w_selOneHot;
                        r_chPattern <= r_pattern;
                        r_chFreq    <= r_freqReg;
                        r_chSlow    <= r_slowReg;
                        r_chFast    <= r_fastReg;
                        r_chMode    <= r_mode;
                    end
                end
            end

            if (r_state == S_EXEC && w_next == S_START) begin
                r_start <= w_selOneHot;
            end

            if (w_next == S_ACK) begin
                r_txStart <= 1'b1;
                r_txData  <= {r_cmd[3:0], w_ackStatus};
            end
        end
    end

    assign ch_load_o    = r_load;
    assign ch_start_o   = r_start;
    assign ch_stop_o    = r_stop;
    assign ch_pattern_o = r_chPattern;
    assign ch_freq_o    = r_chFreq;
    assign ch_slow_o    = r_chSlow;
    assign ch_fast_o    = r_chFast;
    assign ch_mode_o    = r_chMode;
    assign tx_start_o   = r_txStart;
    assign tx_data_o    = r_txData;
    assign busy_o       = (r_state != S_IDLE);
    assign overrun_o    = r_overrun;

endmodule
